mem_access_unit: RTL and testbench

- MEM-stage responder for the memRead/memWrite/funct3 controls produced by instruction decode.
- Turns one load or store into a single word-aligned bus transaction with byte strobes, and formats load data (sign/zero extension).
- Stalls the pipeline until the access completes, and reports alignment, illegal-width and timeout faults.

---
 rtl/mem_access_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store responder. It turns one decoded load or store into a
// single word-aligned bus transaction with byte strobes and formats the load
// result (sign/zero extension). It stalls the pipeline until the access ends
// and flags misaligned, illegal-width and timed-out accesses.
//
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles allowed before the access faults (0 = never)
//   ADDR_W         : address bus width
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   memRead, memWrite          : load / store request from EX/MEM
//   funct3                     : width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, wdata                : byte address, store data (rs2)
//   stall                      : freezes PC and IF/ID/EX/MEM registers
//   done                       : one-cycle completion pulse
//   rdata                      : formatted load result (valid with done)
//   access_fault               : qualifies done: misaligned/illegal/timeout
//   bus_req, bus_we            : bus request, write enable
//   bus_addr                   : word-aligned address
//   bus_wstrb, bus_wdata       : byte-lane enables, lane-replicated data
//   bus_ack, bus_rdata         : one-cycle completion, read word
//
// Optional feature (macro MEM_ACCESS_STATS_EN)
//   load_count, store_count, fault_count : 32-bit wrapping access counters
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              access_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]       load_count,
  output logic [31:0]       store_count,
  output logic [31:0]       fault_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;

  logic             req;
  logic             req_fault;
  logic [3:0]       st_strb;
  logic [31:0]      st_data;
  logic [31:0]      ld_data;
  logic             tmo_hit;

  assign req     = memRead | memWrite;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

  // Outputs decoded straight from the state register so reset clears them
  // asynchronously and bus_req drops the moment rst_n falls.
  assign stall   = ((state == S_IDLE) && req) || (state == S_WAIT);
  assign done    = (state == S_DONE);
  assign bus_req = (state == S_WAIT);

  // Fault classification of the request presented in IDLE.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    req_fault = 1'b0;
    if (memRead && memWrite) begin
      req_fault = 1'b1;
    end else if (memRead) begin
      case (funct3)
        3'b011, 3'b110, 3'b111: req_fault = 1'b1;
        default:                req_fault = 1'b0;
      endcase
    end else if (memWrite) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: req_fault = 1'b0;
        default:                req_fault = 1'b1;
      endcase
    end
    // Alignment: funct3[1:0] encodes the width for both signed and unsigned.
    if (funct3[1:0] == 2'b01 && addr[0])          req_fault = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) req_fault = 1'b1;
  end

  // Store lane placement: strobes follow the byte offset, data is replicated
  // so the selected lanes always carry the right bytes.
  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  // Load formatting from the latched width and byte offset.
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb      = bus_rdata[8*lo_q +: 8];
    lh      = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_data = bus_rdata;
    case (f3_q)
      3'b000:  ld_data = {{24{lb[7]}}, lb};
      3'b100:  ld_data = {24'h0, lb};
      3'b001:  ld_data = {{16{lh[15]}}, lh};
      3'b101:  ld_data = {16'h0, lh};
      default: ld_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req) state_next = req_fault ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (bus_ack || tmo_hit) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      f3_q         <= '0;
      lo_q         <= '0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wstrb    <= '0;
      bus_wdata    <= '0;
      rdata        <= '0;
      access_fault <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req && req_fault) begin
            rdata        <= '0;
            access_fault <= 1'b1;
          end else if (req) begin
            wait_cnt  <= '0;
            f3_q      <= funct3;
            lo_q      <= addr[1:0];
            bus_we    <= memWrite;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_wstrb <= memWrite ? st_strb : 4'b0000;
            bus_wdata <= st_data;
          end
        end
        S_WAIT: begin
          // An ack in the timeout cycle still completes the access normally.
          if (bus_ack) begin
            rdata        <= bus_we ? 32'h0 : ld_data;
            access_fault <= 1'b0;
          end else if (tmo_hit) begin
            rdata        <= '0;
            access_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  // bus_we is only latched for legal accesses, so it is valid whenever the
  // finishing access did not fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count  <= '0;
      store_count <= '0;
      fault_count <= '0;
    end else if (state == S_DONE) begin
      if (access_fault)  fault_count <= fault_count + 1'b1;
      else if (bus_we)   store_count <= store_count + 1'b1;
      else               load_count  <= load_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4). Directed
// accesses followed by random ones; expected values come from a behavioural
// model of the load/store rules. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, done, access_fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] load_count, store_count, fault_count;
`endif

  int errors = 0;
  int checks = 0;
  int m_loads = 0, m_stores = 0, m_faults = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .access_fault(access_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
`ifdef MEM_ACCESS_STATS_EN
    , .load_count(load_count), .store_count(store_count),
    .fault_count(fault_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----------------------------------------------------
  function automatic bit model_fault(bit rd, bit wr, int f3, int unsigned a);
    if (rd && wr) return 1'b1;
    if (rd && !(f3 inside {0, 1, 2, 4, 5})) return 1'b1;
    if (wr && !(f3 inside {0, 1, 2})) return 1'b1;
    if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1'b1;
    if (f3 == 2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned model_load(int f3, int unsigned lo, int unsigned word);
    int unsigned v;
    v = word;
    if (f3 == 0 || f3 == 4) begin
      v = (word >> (8 * lo)) % 256;
      if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (word >> (16 * (lo / 2))) % 65536;
      if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic int unsigned model_strb(int f3, int unsigned lo);
    if (f3 == 0) return 1 << lo;
    if (f3 == 1) return 3 << (2 * (lo / 2));
    return 15;
  endfunction

  function automatic int unsigned model_wdata(int f3, int unsigned wd);
    if (f3 == 0) return (wd % 256) * 32'h0101_0101;
    if (f3 == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  // ---- one access, cycle by cycle -----------------------------------------
  // ack_at: WAIT cycle (1-based) carrying bus_ack; 0 = never acknowledged.
  task automatic run_access(
    input  bit rd, input bit wr, input int f3, input int unsigned a,
    input  int unsigned wd, input int ack_at, input int unsigned word,
    output int stall_n, output int req_n, output logic [31:0] got_rdata,
    output logic got_fault, output logic [31:0] got_addr,
    output logic [3:0] got_strb, output logic [31:0] got_wdata);
    bit exp_fault;
    bit fin;
    int k;
    stall_n = 0; req_n = 0;
    got_addr = 'x; got_strb = 'x; got_wdata = 'x;
    exp_fault = model_fault(rd, wr, f3, a);

    @(negedge clk);
    memRead = rd; memWrite = wr; funct3 = 3'(f3); addr = a; wdata = wd;
    #1;
    check("idle_stall", {31'h0, stall}, 32'h1);
    check("idle_done", {31'h0, done}, 32'h0);
    stall_n += int'(stall); req_n += int'(bus_req);

    if (!exp_fault) begin
      k = 1; fin = 1'b0;
      @(negedge clk);
      while (!fin) begin
        stall_n += int'(stall); req_n += int'(bus_req);
        check("wait_req", {31'h0, bus_req}, 32'h1);
        check("wait_stall", {31'h0, stall}, 32'h1);
        check("wait_addr", bus_addr, a & 32'hFFFF_FFFC);
        check("wait_we", {31'h0, bus_we}, {31'h0, wr});
        check("wait_strb", {28'h0, bus_wstrb}, wr ? model_strb(f3, a % 4) : 32'h0);
        if (wr) check("wait_wdata", bus_wdata, model_wdata(f3, wd));
        if (k == 1) begin
          got_addr = bus_addr; got_strb = bus_wstrb; got_wdata = bus_wdata;
        end
        // Inputs are don't-care while the access is in flight.
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (k == ack_at) begin
          bus_ack = 1'b1; bus_rdata = word;
        end else begin
          bus_rdata = $urandom;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        if (k == ack_at) begin
          fin = 1'b1;
        end else if (k == TMO) begin
          exp_fault = 1'b1; fin = 1'b1;
        end else if (k > TMO + 2) begin
          check("wait_bound", 32'h1, 32'h0);
          fin = 1'b1;
        end else begin
          k++;
        end
      end
    end else begin
      @(negedge clk);
    end

    // DONE cycle
    memRead = 1'b0; memWrite = 1'b0;
    #1;
    got_rdata = rdata; got_fault = access_fault;
    check("done_pulse", {31'h0, done}, 32'h1);
    check("done_stall", {31'h0, stall}, 32'h0);
    check("done_req", {31'h0, bus_req}, 32'h0);
    check("done_fault", {31'h0, access_fault}, {31'h0, exp_fault});
    if (exp_fault) check("done_rdata_fault", rdata, 32'h0);
    else if (rd) check("done_rdata", rdata, model_load(f3, a % 4, word));

    if (exp_fault) m_faults++;
    else if (wr) m_stores++;
    else m_loads++;

    @(negedge clk);
    check("post_done", {31'h0, done}, 32'h0);
    check("post_hold_fault", {31'h0, access_fault}, {31'h0, exp_fault});
`ifdef MEM_ACCESS_STATS_EN
    check("stat_loads", load_count, m_loads);
    check("stat_stores", store_count, m_stores);
    check("stat_faults", fault_count, m_faults);
`endif
  endtask

  initial begin
    int sn, rn;
    logic [31:0] gr, ga, gw;
    logic gf;
    logic [3:0] gs;

    // Reset state
    #12;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_req", {31'h0, bus_req}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_fault", {31'h0, access_fault}, 32'h0);
    check("rst_strb", {28'h0, bus_wstrb}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW 0x100, ack on 3rd WAIT cycle
    run_access(1, 0, 2, 32'h100, 0, 3, 32'hDEAD_BEEF, sn, rn, gr, gf, ga, gs, gw);
    check("lw_addr", ga, 32'h100);
    check("lw_stall_cycles", sn, 4);
    check("lw_rdata", gr, 32'hDEAD_BEEF);
    check("lw_fault", {31'h0, gf}, 32'h0);

    // LB / LBU 0x103
    run_access(1, 0, 0, 32'h103, 0, 1, 32'h80FF_0000, sn, rn, gr, gf, ga, gs, gw);
    check("lb_rdata", gr, 32'hFFFF_FF80);
    run_access(1, 0, 4, 32'h103, 0, 2, 32'h80FF_0000, sn, rn, gr, gf, ga, gs, gw);
    check("lbu_rdata", gr, 32'h0000_0080);

    // SH 0x202
    run_access(0, 1, 1, 32'h202, 32'h1234_ABCD, 1, 0, sn, rn, gr, gf, ga, gs, gw);
    check("sh_addr", ga, 32'h200);
    check("sh_strb", {28'h0, gs}, 32'hC);
    check("sh_wdata", gw, 32'hABCD_ABCD);

    // Misaligned LW: no bus request, single stall cycle
    run_access(1, 0, 2, 32'h101, 0, 1, 0, sn, rn, gr, gf, ga, gs, gw);
    check("mis_fault", {31'h0, gf}, 32'h1);
    check("mis_rdata", gr, 32'h0);
    check("mis_stall_cycles", sn, 1);
    check("mis_req_cycles", rn, 0);

    // SW never acknowledged: timeout after TMO request cycles
    run_access(0, 1, 2, 32'h300, 32'h5555_AAAA, 0, 0, sn, rn, gr, gf, ga, gs, gw);
    check("tmo_req_cycles", rn, TMO);
    check("tmo_fault", {31'h0, gf}, 32'h1);

    // Ack in the timeout cycle wins
    run_access(1, 0, 2, 32'h400, 0, TMO, 32'h0BAD_F00D, sn, rn, gr, gf, ga, gs, gw);
    check("ack_at_tmo_fault", {31'h0, gf}, 32'h0);
    check("ack_at_tmo_rdata", gr, 32'h0BAD_F00D);

    // Illegal requests
    run_access(1, 1, 2, 32'h500, 0, 1, 0, sn, rn, gr, gf, ga, gs, gw);
    run_access(1, 0, 3, 32'h500, 0, 1, 0, sn, rn, gr, gf, ga, gs, gw);
    run_access(0, 1, 4, 32'h500, 0, 1, 0, sn, rn, gr, gf, ga, gs, gw);
    check("illegal_req_cycles", rn, 0);

    // Random accesses
    for (int i = 0; i < 60; i++) begin
      int sel, f3, ack;
      int unsigned a;
      bit rd, wr;
      sel = $urandom_range(0, 9);
      rd = (sel <= 5); wr = (sel == 0) || (sel >= 6);
      f3 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7)
         : (rd ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 2)));
      if (rd && f3 == 3) f3 = 4;
      if (rd && !wr && f3 == 4 && $urandom_range(0, 1) == 1) f3 = 5;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      ack = $urandom_range(0, TMO);
      if (!model_fault(rd, wr, f3, a) && wr && ack == 0 && $urandom_range(0, 1) == 1) ack = 1;
      run_access(rd, wr, f3, a, $urandom, ack, $urandom, sn, rn, gr, gf, ga, gs, gw);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1;
        check("idle_no_req_stall", {31'h0, stall}, 32'h0);
        check("idle_no_req_done", {31'h0, done}, 32'h0);
      end
    end

    // Reset asserted mid-access
    @(negedge clk);
    memWrite = 1'b1; funct3 = 3'b010; addr = 32'h600; wdata = 32'h1;
    @(negedge clk);
    check("rst_mid_req_before", {31'h0, bus_req}, 32'h1);
    #2;
    rst_n = 1'b0; memWrite = 1'b0;
    #1;
    check("rst_mid_req", {31'h0, bus_req}, 32'h0);
    check("rst_mid_stall", {31'h0, stall}, 32'h0);
    check("rst_mid_done", {31'h0, done}, 32'h0);
    m_loads = 0; m_stores = 0; m_faults = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_after_done", {31'h0, done}, 32'h0);
    check("rst_mid_after_req", {31'h0, bus_req}, 32'h0);

    // Post-reset: two loads, one store, one misaligned access
    run_access(1, 0, 2, 32'h700, 0, 1, 32'h1111_2222, sn, rn, gr, gf, ga, gs, gw);
    run_access(1, 0, 5, 32'h702, 0, 2, 32'h8765_4321, sn, rn, gr, gf, ga, gs, gw);
    check("lhu_rdata", gr, 32'h0000_8765);
    run_access(0, 1, 0, 32'h701, 32'hAB, 1, 0, sn, rn, gr, gf, ga, gs, gw);
    run_access(0, 1, 1, 32'h703, 32'hAB, 1, 0, sn, rn, gr, gf, ga, gs, gw);
`ifdef MEM_ACCESS_STATS_EN
    check("stat_final_loads", load_count, 32'd2);
    check("stat_final_stores", store_count, 32'd1);
    check("stat_final_faults", fault_count, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
